visit_requester: RTL
====================

# visit_requester

- Initiator side of the per-vertex visited test-and-set port in the BFS engine.
- Accepts a stream of candidate neighbour vertex addresses from adjacency expansion and issues one test-and-set query at a time to the visited bitmap responder.
- Forwards only newly visited vertices to the frontier queue and drops already-visited ones.
- Sits between the adjacency-list walker and the frontier FIFO, and reports end-of-list and lost-response errors.

## Interface
Parameters:
- PROC_BITS, 0, extra upper address bits for processor/partition tagging; vertex address width is 32+PROC_BITS.
- CNT_W, 16, width of discovered-vertex counter.
- TIMEOUT, 16, max cycles to wait for a responder reply before flagging error (must be ≥ 5).

Ports:
- Clocking and reset (already decided): single clock `clk_in`; `rst_in` is asynchronous, active-low. All state clears immediately on `rst_in`=0.
- clk_in  input  1  clock
- rst_in  input  1  async active-low reset
- nbr_addr_in  input  32+PROC_BITS  candidate neighbour vertex
- nbr_last_in  input  1  marks final neighbour of current list
- nbr_valid_in  input  1  candidate valid
- nbr_ready_out  output  1  requester can accept candidate
- v_addr_out  output  32+PROC_BITS  query address to visited responder
- v_addr_valid_out  output  1  one-cycle query strobe
- visited_in  input  1  responder result: 1 = already visited, 0 = newly marked
- valid_v_in  input  1  responder result strobe
- frontier_addr_out  output  32+PROC_BITS  newly discovered vertex
- frontier_valid_out  output  1  frontier push valid
- frontier_ready_in  input  1  frontier FIFO can accept
- done_out  output  1  one-cycle pulse: last neighbour retired
- discovered_count_out  output  CNT_W  vertices pushed to frontier since reset, saturating
- timeout_err_out  output  1  sticky: responder failed to answer

## Operation
- Reset values: nbr_ready_out=0, v_addr_out=0, v_addr_valid_out=0, frontier_addr_out=0, frontier_valid_out=0, done_out=0, discovered_count_out=0, timeout_err_out=0. The FSM enters IDLE.
- FSM states: IDLE, REQ, WAIT, PUSH, ERR.
- IDLE:
  - nbr_ready_out=1.
  - On nbr_valid_in: capture addr and last into registers, then go to REQ.
- REQ:
  - v_addr_valid_out=1 for exactly one cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - On valid_v_in with visited_in=1: drop the candidate. If last, pulse done_out. Go to IDLE.
  - On valid_v_in with visited_in=0: load frontier_addr_out, then go to PUSH.
  - If the timeout counter reaches TIMEOUT-1 with no valid_v_in: set timeout_err_out and go to ERR.
- PUSH:
  - frontier_valid_out=1, with addr held, until frontier_ready_in.
  - On the handshake: increment discovered_count_out (saturating at 2^CNT_W-1). If last, pulse done_out. Go to IDLE.
- ERR:
  - All handshakes are deasserted.
  - The block remains in ERR until reset.
- Only one query is ever outstanding. v_addr_out holds the captured address stable from REQ through the end of WAIT, because the responder writes the bit using the live address several cycles after the strobe.
- valid_v_in outside WAIT is ignored.
- nbr_ready_out is 0 in every state except IDLE.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- Candidate accepted at edge N. v_addr_valid_out is high in cycle N+1.
- Responder latency is any value from 1 to TIMEOUT-1 cycles after the strobe. The current responder answers in 3 cycles (visited) or 4 (newly marked).
- Visited candidate: nbr_ready_out returns 1 in the cycle after valid_v_in.
- New candidate: frontier_valid_out rises in the cycle after valid_v_in.
- done_out is registered: it is high the cycle after the retiring event (drop or push handshake).
- Reset mid-operation:
  - Any in-flight responder reply arrives while in IDLE and is ignored.
  - A candidate captured but not yet retired is lost. The upstream walker is reset together with this block.

## Structure
- Shared package (the BFS package) holds the `visit_req_state_t` enum and the vertex address width expression 32+PROC_BITS as a localparam-style function/constant.
- No sub-module is required. A saturating counter is inline.
- The visited responder is instantiated beside this block in the parent, not inside it.

## Test plan
- Single new vertex:
  - Stimulus: nbr 0x0000_0005, last=1; responder replies visited_in=0 after 4 cycles; frontier_ready_in=1.
  - Required response: one frontier push of 0x5, count=1, done_out pulses once.
- Repeat vertex:
  - Stimulus: 0x5 then 0x5 against the real responder model.
  - Required response: the first is pushed, the second is dropped; count=1; no second frontier_valid_out.
- Frontier backpressure:
  - Stimulus: frontier_ready_in=0 for 10 cycles during PUSH.
  - Required response: frontier_valid_out and addr are held stable, nbr_ready_out=0 throughout, count increments exactly once on release.
- Lost reply:
  - Stimulus: responder never asserts valid_v_in.
  - Required response: timeout_err_out=1 exactly TIMEOUT cycles after the strobe, sticky; nbr_ready_out stays 0.
- Async reset during WAIT:
  - Stimulus: drive rst_in=0 mid-cycle.
  - Required response: outputs clear without a clock edge; a late valid_v_in after release produces no push.
- Saturation and spurious strobes:
  - Stimulus: CNT_W=2 and 5 new vertices; also a spurious valid_v_in while in IDLE.
  - Required response: count stops at 3; the spurious strobe has no effect.

Source files
------------

// File: rtl/bfs_pkg.sv
// Shared BFS engine types: visited-requester FSM states and vertex address width.
package bfs_pkg;

  localparam int unsigned VADDR_BASE_W = 32;

  typedef enum logic [2:0] {
    VR_IDLE,
    VR_REQ,
    VR_WAIT,
    VR_PUSH,
    VR_ERR
  } visit_req_state_t;

  function automatic int unsigned vaddr_w(input int unsigned proc_bits);
    return VADDR_BASE_W + proc_bits;
  endfunction

endpackage

// File: rtl/visit_requester.sv
// Visited test-and-set initiator: one outstanding query per candidate, forwards new vertices to the frontier.
// All outputs registered; a lost responder reply parks the block in ERR until reset.
module visit_requester
  import bfs_pkg::*;
#(
  parameter int unsigned PROC_BITS = 0,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [vaddr_w(PROC_BITS)-1:0]  nbr_addr_in,
  input  logic                           nbr_last_in,
  input  logic                           nbr_valid_in,
  output logic                           nbr_ready_out,
  output logic [vaddr_w(PROC_BITS)-1:0]  v_addr_out,
  output logic                           v_addr_valid_out,
  input  logic                           visited_in,
  input  logic                           valid_v_in,
  output logic [vaddr_w(PROC_BITS)-1:0]  frontier_addr_out,
  output logic                           frontier_valid_out,
  input  logic                           frontier_ready_in,
  output logic                           done_out,
  output logic [CNT_W-1:0]               discovered_count_out,
  output logic                           timeout_err_out
);

  localparam int unsigned AW = vaddr_w(PROC_BITS);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  visit_req_state_t r_state;
  logic             r_last;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_nbr_rdy;
  logic [AW-1:0]    r_v_addr;
  logic             r_v_vld;
  logic [AW-1:0]    r_fr_addr;
  logic             r_fr_vld;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tmo_err;

  assign nbr_ready_out        = r_nbr_rdy;
  assign v_addr_out           = r_v_addr;
  assign v_addr_valid_out     = r_v_vld;
  assign frontier_addr_out    = r_fr_addr;
  assign frontier_valid_out   = r_fr_vld;
  assign done_out             = r_done;
  assign discovered_count_out = r_cnt;
  assign timeout_err_out      = r_tmo_err;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= VR_IDLE;
      r_last    <= 1'b0;
      r_tmo_cnt <= '0;
      r_nbr_rdy <= 1'b0;
      r_v_addr  <= '0;
      r_v_vld   <= 1'b0;
      r_fr_addr <= '0;
      r_fr_vld  <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_v_vld <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        VR_IDLE: begin
          if (r_nbr_rdy && nbr_valid_in) begin
            r_v_addr  <= nbr_addr_in;
            r_last    <= nbr_last_in;
            r_nbr_rdy <= 1'b0;
            r_v_vld   <= 1'b1;
            r_state   <= VR_REQ;
          end else begin
            r_nbr_rdy <= 1'b1;
          end
        end
        VR_REQ: begin
          // The strobe cycle itself counts as the first waited cycle.
          r_tmo_cnt <= TW'(1);
          r_state   <= VR_WAIT;
        end
        VR_WAIT: begin
          if (valid_v_in) begin
            if (visited_in) begin
              r_done    <= r_last;
              r_nbr_rdy <= 1'b1;
              r_state   <= VR_IDLE;
            end else begin
              r_fr_addr <= r_v_addr;
              r_fr_vld  <= 1'b1;
              r_state   <= VR_PUSH;
            end
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_tmo_err <= 1'b1;
            r_state   <= VR_ERR;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        VR_PUSH: begin
          if (frontier_ready_in) begin
            r_fr_vld  <= 1'b0;
            r_done    <= r_last;
            r_nbr_rdy <= 1'b1;
            r_state   <= VR_IDLE;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          end
        end
        VR_ERR: begin
          r_nbr_rdy <= 1'b0;
          r_fr_vld  <= 1'b0;
        end
        default: r_state <= VR_IDLE;
      endcase
    end
  end

endmodule
